pr_coder: RTL and testbench

- Parameterised priority encoder: reports the bit index of the most-significant set bit of an input vector.
- Registered output with a valid/zero qualifier.
- Used wherever leading-one position is needed (normalisation, arbitration, log2 estimation).
- Single clock domain; one-cycle latency.

---
 rtl/pr_coder.sv | 74 +++++++
 tb/tb_pr_coder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pr_coder.sv
// pr_coder: registered priority encoder returning the index of the most-significant
// set bit of num, with a one-cycle out_valid pulse and a zero flag for an all-zero input.
// Optional feature: define PR_CODER_ONEHOT_EN to add a registered onehot output that
// isolates the highest set bit of num.
module pr_coder #(
   parameter int NUM_SIZE = 16,
   parameter int OUT_SIZE = $clog2(NUM_SIZE)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [NUM_SIZE-1:0] num,
`ifdef PR_CODER_ONEHOT_EN
   output logic [NUM_SIZE-1:0] onehot,
`endif
   output logic [OUT_SIZE-1:0] out,
   output logic                out_valid,
   output logic                zero
);

   logic [OUT_SIZE-1:0] idx;
   logic                is_zero;
   logic [NUM_SIZE-1:0] onehot_c;

   // Leading-one search: ascending scan, so the highest set bit is the last one written.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no latch is inferred
      // and an all-zero num still yields fully defined outputs.
      idx      = '0;
      is_zero  = 1'b1;
      onehot_c = '0;
      for (int i = 0; i < NUM_SIZE; i++) begin
         if (num[i]) begin
            idx         = OUT_SIZE'(i);
            is_zero     = 1'b0;
            onehot_c    = '0;
            onehot_c[i] = 1'b1;
         end
      end
   end

   // Result register: capture on in_valid, otherwise hold data and drop out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         out       <= '0;
         zero      <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out  <= idx;
            zero <= is_zero;
         end
      end
   end

`ifdef PR_CODER_ONEHOT_EN
   // Onehot register follows exactly the same capture and reset rules as out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         onehot <= '0;
      end else if (in_valid) begin
         onehot <= onehot_c;
      end
   end
`else
   // Onehot value is unused when the optional output is not built.
   logic unused_onehot;
   assign unused_onehot = ^onehot_c;
`endif

endmodule

// File: tb/tb_pr_coder.sv
// tb_pr_coder: table-driven check of pr_coder (NUM_SIZE=16, OUT_SIZE=4) plus
// hand-written sequences for asynchronous reset and mid-stream reset.
module tb_pr_coder;

   localparam int NUM_SIZE = 16;
   localparam int OUT_SIZE = 4;

   logic                clk;
   logic                clk_en;
   logic                rst_n;
   logic                in_valid;
   logic [NUM_SIZE-1:0] num;
   logic [OUT_SIZE-1:0] out;
   logic                out_valid;
   logic                zero;
`ifdef PR_CODER_ONEHOT_EN
   logic [NUM_SIZE-1:0] onehot;
`endif

   pr_coder #(.NUM_SIZE(NUM_SIZE), .OUT_SIZE(OUT_SIZE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .num       (num),
`ifdef PR_CODER_ONEHOT_EN
      .onehot    (onehot),
`endif
      .out       (out),
      .out_valid (out_valid),
      .zero      (zero)
   );

   // Gated clock so reset can be checked with the clock stopped.
   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   typedef struct {
      logic [NUM_SIZE-1:0] num;
      logic                in_valid;
      logic [OUT_SIZE-1:0] exp_out;
      logic                exp_zero;
      logic                exp_valid;
      logic [NUM_SIZE-1:0] exp_oh;
   } vec_t;

   vec_t vecs[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic check_all(input string tag, input logic [OUT_SIZE-1:0] e_out,
                            input logic e_zero, input logic e_valid,
                            input logic [NUM_SIZE-1:0] e_oh);
      check({tag, " out"},       32'(out),       32'(e_out));
      check({tag, " zero"},      32'(zero),      32'(e_zero));
      check({tag, " out_valid"}, 32'(out_valid), 32'(e_valid));
`ifdef PR_CODER_ONEHOT_EN
      check({tag, " onehot"},    32'(onehot),    32'(e_oh));
`else
      if (e_oh === 'x) $display("unexpected onehot expectation in %s", tag);
`endif
   endtask

   // Drive inputs away from the active edge, then sample just after it.
   task automatic step(input logic [NUM_SIZE-1:0] n, input logic v);
      @(negedge clk);
      num      = n;
      in_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [NUM_SIZE-1:0] n, input logic v,
                      input logic [OUT_SIZE-1:0] o, input logic z, input logic ov,
                      input logic [NUM_SIZE-1:0] oh);
      vec_t e;
      e.num = n; e.in_valid = v; e.exp_out = o; e.exp_zero = z;
      e.exp_valid = ov; e.exp_oh = oh;
      vecs.push_back(e);
   endtask

   initial begin
      clk_en   = 1'b0;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      num      = '0;

      // Idle after reset release: reset values persist, no valid pulses.
      for (int k = 0; k < 3; k++) add(16'h0000, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000);
      // Back-to-back samples including both extremes.
      add(16'h8000, 1'b1, 4'd15, 1'b0, 1'b1, 16'h8000);
      add(16'h0001, 1'b1, 4'd0,  1'b0, 1'b1, 16'h0001);
      add(16'hFFFF, 1'b1, 4'd15, 1'b0, 1'b1, 16'h8000);
      // Mixed patterns: lower set bits must be ignored.
      add(16'h1234, 1'b1, 4'd12, 1'b0, 1'b1, 16'h1000);
      add(16'h00F3, 1'b1, 4'd7,  1'b0, 1'b1, 16'h0080);
      add(16'h0400, 1'b1, 4'd10, 1'b0, 1'b1, 16'h0400);
      // Leading-zero sweep, then an all-zero input.
      for (int k = 0; k < 16; k++)
         add(16'hFFFF >> k, 1'b1, 4'(15 - k), 1'b0, 1'b1, 16'h8000 >> k);
      add(16'h0000, 1'b1, 4'd0, 1'b1, 1'b1, 16'h0000);
      // Hold: result persists while in_valid is low and num changes.
      add(16'h0020, 1'b1, 4'd5, 1'b0, 1'b1, 16'h0020);
      add(16'hA5C3, 1'b0, 4'd5, 1'b0, 1'b0, 16'h0020);
      add(16'h7FFF, 1'b0, 4'd5, 1'b0, 1'b0, 16'h0020);
      add(16'h0000, 1'b0, 4'd5, 1'b0, 1'b0, 16'h0020);
      add(16'h8001, 1'b0, 4'd5, 1'b0, 1'b0, 16'h0020);

      // Asynchronous reset with the clock stopped.
      #3 rst_n = 1'b0;
      #1 check_all("async_rst", 4'd0, 1'b1, 1'b0, 16'h0000);

      clk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].num, vecs[i].in_valid);
         check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_zero,
                   vecs[i].exp_valid, vecs[i].exp_oh);
      end

      // Mid-stream reset: a sample is in flight when rst_n drops.
      step(16'h00F3, 1'b1);
      check_all("pre_rst", 4'd7, 1'b0, 1'b1, 16'h0080);
      num = 16'hFFFF;
      #2 rst_n = 1'b0;
      #1 check_all("mid_rst", 4'd0, 1'b1, 1'b0, 16'h0000);
      @(posedge clk); #1;
      check_all("in_rst", 4'd0, 1'b1, 1'b0, 16'h0000);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step(16'h0000, 1'b0);
      check_all("post_rst_idle", 4'd0, 1'b1, 1'b0, 16'h0000);
      step(16'h0001, 1'b1);
      check_all("post_rst_bit0", 4'd0, 1'b0, 1'b1, 16'h0001);
      step(16'h0300, 1'b1);
      check_all("post_rst_b2b", 4'd9, 1'b0, 1'b1, 16'h0200);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
